// File: rtl/ram_bus_responder.sv
// ram_bus_responder: RAM-side responder at the far end of the address bus.
// A request is accepted in IDLE. The responder then inserts WAIT_CYCLES wait
// states and performs one word access on an internal RAM. A one-cycle ready
// pulse completes every request.
//
// Optional build macro RAM_ADDR_RANGE_CHECK_EN: addresses with any bit set
// above ADDR_BITS are rejected and flagged on error. Without it, those bits
// are ignored and addresses alias modulo 2**ADDR_BITS.
//
// Ports:
//   clk, rst_n  - clock and asynchronous active-low reset
//   EN          - request strobe, sampled only in IDLE
//   addressIn   - 32-bit word address
//   writeEn     - 1 = write request, 0 = read request
//   fetch       - 1 = read result goes to instrOut, 0 = to dataOut
//   dataIn      - write data
//   instrOut    - last fetched instruction word
//   dataOut     - last read data word
//   ready       - one-cycle completion pulse
//   busy        - high while a request is in flight
//   error       - out-of-range flag, pulsed with ready
module ram_bus_responder #(
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic [31:0] addressIn,
    input  logic        writeEn,
    input  logic        fetch,
    input  logic [31:0] dataIn,
    output logic [31:0] instrOut,
    output logic [31:0] dataOut,
    output logic        ready,
    output logic        busy,
    output logic        error
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DW    = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic                   we_q, we_d;
    logic                   fetch_q, fetch_d;
    logic [DW-1:0]          wdata_q, wdata_d;
    logic [DW-1:0]          instr_q, instr_d;
    logic [DW-1:0]          data_q, data_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   error_q, error_d;
    logic                   oor_q, oor_d;
    logic                   access_ok_c;
    logic                   mem_we_c;

    logic [DW-1:0]          mem [DEPTH];

`ifdef RAM_ADDR_RANGE_CHECK_EN
    // Any high address bit set at acceptance suppresses the access.
    assign access_ok_c = ~oor_q;
`else
    // High address bits are ignored; fold them into a sink so they are used.
    logic unused_addr_hi_c;
    assign unused_addr_hi_c = ^{addressIn[31:ADDR_BITS], oor_q};
    assign access_ok_c      = 1'b1;
`endif

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        we_d     = we_q;
        fetch_d  = fetch_q;
        wdata_d  = wdata_q;
        instr_d  = instr_q;
        data_d   = data_q;
        ready_d  = ready_q;
        busy_d   = busy_q;
        error_d  = error_q;
        oor_d    = oor_q;
        mem_we_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (EN) begin
                    addr_d  = addressIn[ADDR_BITS-1:0];
                    we_d    = writeEn;
                    fetch_d = fetch;
                    wdata_d = dataIn;
`ifdef RAM_ADDR_RANGE_CHECK_EN
                    oor_d   = |addressIn[31:ADDR_BITS];
`else
                    oor_d   = 1'b0;
`endif
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    busy_d  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Access edge: only place RAM and read outputs change.
                    ready_d = 1'b1;
                    error_d = ~access_ok_c;
                    state_d = ST_RESP;
                    if (access_ok_c) begin
                        if (we_q) begin
                            mem_we_c = 1'b1;
                        end else if (fetch_q) begin
                            instr_d = mem[addr_q];
                        end else begin
                            data_d = mem[addr_q];
                        end
                    end
                end
            end
            ST_RESP: begin
                ready_d = 1'b0;
                busy_d  = 1'b0;
                error_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            fetch_q <= 1'b0;
            wdata_q <= '0;
            instr_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            fetch_q <= fetch_d;
            wdata_q <= wdata_d;
            instr_q <= instr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            error_q <= error_d;
            oor_q   <= oor_d;
        end
    end

    // RAM array; contents survive reset. Reset forces IDLE asynchronously,
    // so a pending write can never reach this port.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign instrOut = instr_q;
    assign dataOut  = data_q;
    assign ready    = ready_q;
    assign busy     = busy_q;
    assign error    = error_q;

endmodule

// File: tb/tb_ram_bus_responder.sv
// Testbench for ram_bus_responder: a WAIT_CYCLES=2 instance checked through a
// scoreboard of expected read outputs, plus a WAIT_CYCLES=0 instance.
module tb_ram_bus_responder;

    localparam int unsigned AB = 8;
    localparam int unsigned W  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en, we, fe;
    logic [31:0] addr, din;
    logic [31:0] instr, dout;
    logic        rdy, bsy, err;

    logic        en0, we0, fe0;
    logic [31:0] addr0, din0;
    logic [31:0] instr0, dout0;
    logic        rdy0, bsy0, err0;

    ram_bus_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .EN(en), .addressIn(addr), .writeEn(we),
        .fetch(fe), .dataIn(din), .instrOut(instr), .dataOut(dout),
        .ready(rdy), .busy(bsy), .error(err)
    );

    ram_bus_responder #(.ADDR_BITS(AB), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .EN(en0), .addressIn(addr0), .writeEn(we0),
        .fetch(fe0), .dataIn(din0), .instrOut(instr0), .dataOut(dout0),
        .ready(rdy0), .busy(bsy0), .error(err0)
    );

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] model_mem [256];
    logic [31:0] exp_instr = '0;
    logic [31:0] exp_data  = '0;
    int          checks    = 0;
    int          failures  = 0;
    int          ready_cnt = 0;

    // Reference model: update expected state for one accepted request.
    task automatic push_expect(input logic [31:0] a, input logic w,
                               input logic f, input logic [31:0] d);
        exp_t e;
        logic oor;
        oor = 1'b0;
`ifdef RAM_ADDR_RANGE_CHECK_EN
        oor = |a[31:AB];
`endif
        if (!oor) begin
            if (w) model_mem[a[AB-1:0]] = d;
            else if (f) exp_instr = model_mem[a[AB-1:0]];
            else exp_data = model_mem[a[AB-1:0]];
        end
        e.instr = exp_instr;
        e.data  = exp_data;
        e.err   = oor;
        sb_q.push_back(e);
    endtask

    // Scoreboard monitor: every ready pulse pops one expectation.
    always @(negedge clk) begin
        if (rst_n && rdy) begin
            ready_cnt++;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL spurious_ready: ready=1 with no request outstanding");
            end else begin
                mon_e = sb_q.pop_front();
                if (instr !== mon_e.instr || dout !== mon_e.data || err !== mon_e.err) begin
                    failures++;
                    $display("FAIL sb_response: instr=%h data=%h err=%b required instr=%h data=%h err=%b",
                             instr, dout, err, mon_e.instr, mon_e.data, mon_e.err);
                end
            end
        end
    end

    // Issue one request once idle; lat = edges from acceptance to ready.
    task automatic issue(input logic [31:0] a, input logic w, input logic f,
                         input logic [31:0] d, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (bsy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        en = 1'b1; addr = a; we = w; fe = f; din = d;
        push_expect(a, w, f, d);
        @(posedge clk);
        #1;
        // Scramble inputs while busy; they must have no effect.
        en = 1'b0; addr = $urandom(); din = $urandom();
        we = 1'($urandom()); fe = 1'($urandom());
        lat = 0;
        while (rdy !== 1'b1 && lat < 50) begin
            @(posedge clk);
            lat++;
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        en = 1'b0; we = 1'b0; fe = 1'b0; addr = '0; din = '0;
        en0 = 1'b0; we0 = 1'b0; fe0 = 1'b0; addr0 = '0; din0 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({instr, dout, rdy, bsy, err} !== 67'd0) begin
            failures++;
            $display("FAIL reset_outputs: instr=%h data=%h rdy=%b busy=%b err=%b required all 0",
                     instr, dout, rdy, bsy, err);
        end
        checks++;
        if ({instr0, dout0, rdy0, bsy0, err0} !== 67'd0) begin
            failures++;
            $display("FAIL reset_outputs_w0: instr=%h data=%h rdy=%b busy=%b err=%b required all 0",
                     instr0, dout0, rdy0, bsy0, err0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_then_fetch;
        int lat;
        issue(32'h0000_000A, 1'b1, 1'b0, 32'h1111_1111, lat);
        checks++;
        if (lat != W + 1) begin
            failures++;
            $display("FAIL wr_latency: got %0d required %0d", lat, W + 1);
        end
        issue(32'h0000_000A, 1'b0, 1'b1, 32'h0, lat);
        checks++;
        if (lat != W + 1) begin
            failures++;
            $display("FAIL fetch_latency: got %0d required %0d", lat, W + 1);
        end
        checks++;
        if (instr !== 32'h1111_1111 || dout !== 32'h0) begin
            failures++;
            $display("FAIL fetch_value: instr=%h data=%h required instr=11111111 data=00000000",
                     instr, dout);
        end
    endtask

    task automatic test_data_read;
        int lat;
        issue(32'h0000_0005, 1'b1, 1'b0, 32'hDEAD_BEEF, lat);
        issue(32'h0000_0005, 1'b0, 1'b0, 32'h0, lat);
        checks++;
        if (dout !== 32'hDEAD_BEEF || instr !== 32'h1111_1111) begin
            failures++;
            $display("FAIL data_read: data=%h instr=%h required data=deadbeef instr=11111111",
                     dout, instr);
        end
    endtask

    task automatic test_busy_ignore;
        int lat, rc0, guard;
        for (int i = 0; i < 8; i++)
            issue(32'h30 + 32'(i), 1'b1, 1'b0, 32'hA500_0000 | 32'(i * 17), lat);
        guard = 0;
        @(negedge clk);
        while (bsy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        rc0 = ready_cnt;
        // EN held high every cycle; acceptances expected every W+3 edges.
        for (int c = 0; c < 4 * (W + 3); c++) begin
            en = 1'b1; we = 1'b0; fe = 1'b0;
            addr = 32'h30 + 32'(c % 8);
            din = $urandom();
            if (c % (W + 3) == 0) push_expect(addr, 1'b0, 1'b0, 32'h0);
            @(negedge clk);
        end
        en = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (ready_cnt - rc0 != 4 || sb_q.size() != 0) begin
            failures++;
            $display("FAIL busy_ignore_count: readies=%0d pending=%0d required readies=4 pending=0",
                     ready_cnt - rc0, sb_q.size());
        end
    endtask

    task automatic test_out_of_range;
        int lat;
        issue(32'h0000_0105, 1'b1, 1'b0, 32'h1234_5678, lat);
        checks++;
        if (lat != W + 1) begin
            failures++;
            $display("FAIL oor_latency: got %0d required %0d", lat, W + 1);
        end
        issue(32'h0000_0005, 1'b0, 1'b0, 32'h0, lat);
        checks++;
`ifdef RAM_ADDR_RANGE_CHECK_EN
        if (dout !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL oor_ram: data=%h required deadbeef", dout);
        end
`else
        if (dout !== 32'h1234_5678) begin
            failures++;
            $display("FAIL alias_ram: data=%h required 12345678", dout);
        end
`endif
    endtask

    task automatic run0(input logic [31:0] a, input logic w, input logic f,
                        input logic [31:0] d, output int rdy_at,
                        output int busy_n, output logic [31:0] d_at);
        @(negedge clk);
        en0 = 1'b1; addr0 = a; we0 = w; fe0 = f; din0 = d;
        @(posedge clk);
        #1;
        en0 = 1'b0; addr0 = $urandom(); din0 = $urandom();
        rdy_at = -1; busy_n = 0; d_at = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bsy0) busy_n++;
            if (rdy0 && rdy_at < 0) begin
                rdy_at = i;
                d_at = f ? instr0 : dout0;
            end
        end
    endtask

    task automatic test_wait0;
        int rdy_at, busy_n;
        logic [31:0] d_at;
        run0(32'h1, 1'b1, 1'b0, 32'hCAFE_F00D, rdy_at, busy_n, d_at);
        run0(32'h1, 1'b0, 1'b0, 32'h0, rdy_at, busy_n, d_at);
        checks++;
        if (rdy_at != 1 || busy_n != 2) begin
            failures++;
            $display("FAIL w0_timing: ready_at=%0d busy_cycles=%0d required ready_at=1 busy_cycles=2",
                     rdy_at, busy_n);
        end
        checks++;
        if (d_at !== 32'hCAFE_F00D || err0 !== 1'b0) begin
            failures++;
            $display("FAIL w0_data: data=%h err=%b required data=cafef00d err=0", d_at, err0);
        end
    endtask

    task automatic test_reset_midwait;
        int lat;
        issue(32'h20, 1'b1, 1'b0, 32'h0101_0101, lat);
        issue(32'h20, 1'b0, 1'b1, 32'h0, lat);
        @(negedge clk);
        en = 1'b1; addr = 32'h20; we = 1'b1; din = 32'hBAD0_BAD0;
        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({instr, dout, rdy, bsy, err} !== 67'd0) begin
            failures++;
            $display("FAIL reset_midwait: instr=%h data=%h rdy=%b busy=%b err=%b required all 0",
                     instr, dout, rdy, bsy, err);
        end
        exp_instr = '0;
        exp_data  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(32'h20, 1'b0, 1'b0, 32'h0, lat);
        checks++;
        if (dout !== 32'h0101_0101) begin
            failures++;
            $display("FAIL aborted_write: data=%h required 01010101", dout);
        end
    endtask

    initial begin
        test_reset();
        test_write_then_fetch();
        test_data_read();
        test_busy_ignore();
        test_out_of_range();
        test_wait0();
        test_reset_midwait();
        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: pending=%0d required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
